// File: rtl/mul_sequencer.sv
// Shift-and-add multiplier that borrows a shared ALU for its accumulate step.
// Every output, including the ALU drive, is registered from the next-state values.
`ifndef WORD
`define WORD 64
`endif
`ifndef ALU_PASS
`define ALU_PASS 4'b0000
`endif
`ifndef ALU_ADD
`define ALU_ADD 4'b0010
`endif

module mul_sequencer #(
  parameter int unsigned EARLY_EXIT = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [`WORD-1:0]   multiplicand,
  input  logic [`WORD-1:0]   multiplier,
  output logic               busy,
  output logic               done,
  output logic [`WORD-1:0]   product,
  output logic [`WORD-1:0]   alu_a_out,
  output logic [`WORD-1:0]   alu_b_out,
  output logic [3:0]         alu_control_out,
  input  logic [`WORD-1:0]   alu_result_in
);

  localparam int unsigned W  = `WORD;
  localparam int unsigned CW = $clog2(W);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [W-1:0]  acc_q, acc_d;
  logic [W-1:0]  mcand_q, mcand_d;
  logic [W-1:0]  mplier_q, mplier_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [W-1:0]  product_q, product_d;
  logic [W-1:0]  alu_a_q, alu_a_d;
  logic [W-1:0]  alu_b_q, alu_b_d;
  logic [3:0]    alu_ctrl_q, alu_ctrl_d;

  // Next-state, datapath and output computation.
  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    cnt_d     = cnt_q;
    product_d = product_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          acc_d    = '0;
          mcand_d  = multiplicand;
          mplier_d = multiplier;
          cnt_d    = '0;
          state_d  = S_RUN;
        end
      end
      S_RUN: begin
        // alu_a/alu_b already hold acc/mcand, so alu_result_in is acc + mcand.
        if (mplier_q[0]) acc_d = alu_result_in;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CW'(1);
        if (((EARLY_EXIT != 0) && (mplier_d == '0)) || (cnt_q == CW'(W - 1))) begin
          state_d = S_DONE;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if ((state_q == S_RUN) && (state_d == S_DONE)) product_d = acc_d;

    busy_d     = (state_d == S_RUN);
    done_d     = (state_d == S_DONE);
    alu_a_d    = busy_d ? acc_d   : '0;
    alu_b_d    = busy_d ? mcand_d : '0;
    alu_ctrl_d = busy_d ? `ALU_ADD : `ALU_PASS;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      acc_q      <= '0;
      mcand_q    <= '0;
      mplier_q   <= '0;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      product_q  <= '0;
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      alu_ctrl_q <= `ALU_PASS;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      mcand_q    <= mcand_d;
      mplier_q   <= mplier_d;
      cnt_q      <= cnt_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      product_q  <= product_d;
      alu_a_q    <= alu_a_d;
      alu_b_q    <= alu_b_d;
      alu_ctrl_q <= alu_ctrl_d;
    end
  end

  assign busy            = busy_q;
  assign done            = done_q;
  assign product         = product_q;
  assign alu_a_out       = alu_a_q;
  assign alu_b_out       = alu_b_q;
  assign alu_control_out = alu_ctrl_q;

endmodule

// File: doc/mul_sequencer.md
MUL_SEQUENCER -- requirements
Module: mul_sequencer

Interface
REQ-001 SHALL have parameter EARLY_EXIT, default 1; 1 ends iteration once the remaining multiplier is zero, 0 always runs `WORD iterations.
REQ-002 SHALL have port clk  input  1  single clock, all state rising-edge triggered.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port start  input  1  request to begin a multiply, sampled only in IDLE.
REQ-005 SHALL have port multiplicand  input  `WORD  operand A, captured on accepted start.
REQ-006 SHALL have port multiplier  input  `WORD  operand B, captured on accepted start.
REQ-007 SHALL have port busy  output  1  high while in RUN.
REQ-008 SHALL have port done  output  1  one-cycle pulse, product valid.
REQ-009 SHALL have port product  output  `WORD  low `WORD bits of A*B, registered.
REQ-010 SHALL have port alu_a_out  output  `WORD  drives shared ALU a_in.
REQ-011 SHALL have port alu_b_out  output  `WORD  drives shared ALU b_in.
REQ-012 SHALL have port alu_control_out  output  4  drives ALU alu_control using the `ALU_* encodings.
REQ-013 SHALL have port alu_result_in  input  `WORD  from ALU alu_result, combinational same cycle.

Function
REQ-014 SHALL implement FSM states IDLE, RUN, DONE with internal registers acc, mcand, mplier (each `WORD) and iteration counter cnt.
REQ-015 IDLE: start=1 -> load acc=0, mcand=multiplicand, mplier=multiplier, cnt=0, go RUN. start=0 -> stay.
REQ-016 RUN, every cycle: drive alu_a_out=acc, alu_b_out=mcand, alu_control_out=`ALU_ADD.
REQ-017 RUN, at the edge: if mplier[0]=1 then acc<=alu_result_in, else acc holds. Also mcand<<=1 (zero fill, MSB dropped), mplier>>=1 (logical), cnt++.
REQ-018 RUN exit to DONE, evaluated at the same edge:
- EARLY_EXIT=1: (mplier>>1)==0.
- Either setting: cnt==`WORD-1.
REQ-019 RUN cycle count N = max(1, p+1) with EARLY_EXIT=1, where p = index of highest set bit of multiplier. N = `WORD with EARLY_EXIT=0.
REQ-020 DONE: product<=acc on entry; done=1 for exactly this one cycle; unconditional return to IDLE next edge.
REQ-021 product SHALL hold its value until the next DONE.
REQ-022 Latency: start accepted at edge t -> done high in the cycle after edge t+N.
REQ-023 Outside RUN: alu_control_out=`ALU_PASS, alu_a_out=0, alu_b_out=0, so the shared ALU is idle-safe.
REQ-024 start in RUN or DONE SHALL be ignored; no queuing. Operand changes after acceptance SHALL have no effect.
REQ-025 Overflow SHALL truncate silently to `WORD bits. Operands are treated as unsigned; low-word result is identical for two's-complement signed.
REQ-026 busy and done SHALL never be high simultaneously.

Reset
REQ-027 rst_n=0 SHALL immediately force IDLE and set busy=0, done=0, product=0, acc=mcand=mplier=0, cnt=0, irrespective of clk.
REQ-028 Reset asserted mid-RUN SHALL abort the operation with no done pulse. First start accepted after rst_n rises SHALL behave normally.
REQ-029 ALU drive outputs SHALL take their REQ-023 idle values during reset.

Verification
REQ-030 A=10, B=15, start 1 cycle (EARLY_EXIT=1) -> busy 4 cycles, done pulse 5 cycles after start edge, product=150.
REQ-031 A=256, B=0 -> N=1, done 2 cycles after start, product=0.
REQ-032 A=65536, B=65536 -> product=0x1_0000_0000, N=17. Then A=2^63, B=2 -> product=0 (truncation).
REQ-033 B with bit 63 set (B=2^63, A=1), and separately EARLY_EXIT=0 with B=1 -> both N=64, done 65 cycles after start. Product 2^63 and A, respectively.
REQ-034 start held high continuously through a run, with operands changed mid-RUN -> exactly one done per accepted start, result from the originally captured operands, next start accepted only from IDLE.
REQ-035 rst_n pulsed low during RUN at iteration 3 -> outputs zero asynchronously, no done. A subsequent 7*6 gives product=42.
